// File: rtl/trace_chk_pkg.sv
// Shared types for the writeback-trace checker: result enums and the commit record.
package trace_chk_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } status_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISMATCH = 2'd1,
    OVERFLOW = 2'd2
  } err_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } commit_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of commit records; pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
module trace_fifo
  import trace_chk_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  commit_t din,
  output commit_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  commit_t     r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which slots hold live data.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/debug_trace_checker.sv
// Compares the core's committed register writes, in order, against a golden
// trace stream and latches the first divergence or FIFO overflow.
module debug_trace_checker
  import trace_chk_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit FILTER_R0 = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_debug_pc,
  input  logic [31:0] io_debug_wdata,
  input  logic [4:0]  io_debug_waddr,
  input  logic        io_debug_wen,
  input  logic        golden_valid,
  output logic        golden_ready,
  input  logic [31:0] golden_pc,
  input  logic [31:0] golden_wdata,
  input  logic [4:0]  golden_waddr,
  input  logic        golden_last,
  output logic [1:0]  status,
  output logic [1:0]  err_code,
  output logic [31:0] commit_count,
  output logic [31:0] mis_pc,
  output logic [31:0] mis_wdata,
  output logic [4:0]  mis_waddr
);

  status_t     r_status;
  err_t        r_err;
  logic [31:0] r_commit_count;
  commit_t     r_mis;

  commit_t w_obs;
  commit_t w_gold;
  commit_t w_head;
  logic    w_full;
  logic    w_empty;
  logic    w_enq_req;
  logic    w_push;
  logic    w_cmp;
  logic    w_match;
  logic    w_overflow;

  assign w_obs  = {io_debug_pc, io_debug_waddr, io_debug_wdata};
  assign w_gold = {golden_pc, golden_waddr, golden_wdata};

  assign w_enq_req = io_debug_wen && (r_status == RUN) &&
                     (!FILTER_R0 || (io_debug_waddr != 5'd0));

  assign golden_ready = (r_status == RUN) && !w_empty;
  assign w_cmp        = golden_valid && golden_ready;
  assign w_match      = (w_head == w_gold);
  assign w_overflow   = w_enq_req && w_full && !w_cmp;
  assign w_push       = w_enq_req && (!w_full || w_cmp);

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_cmp),
    .din   (w_obs),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // NOTE: all state updates are non-blocking so every register sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_status       <= RUN;
      r_err          <= NONE;
      r_commit_count <= '0;
      r_mis          <= '0;
    end else if (r_status == RUN) begin
      // A mismatch outranks an overflow in the same cycle, so it is tested first.
      if (w_cmp && !w_match) begin
        r_status <= FAIL;
        r_err    <= MISMATCH;
        r_mis    <= w_head;
      end else if (w_overflow) begin
        r_status <= FAIL;
        r_err    <= OVERFLOW;
        r_mis    <= w_obs;
      end else if (w_cmp) begin
        r_commit_count <= r_commit_count + 32'd1;
        if (golden_last) r_status <= PASS;
      end
    end
  end

  assign status       = r_status;
  assign err_code     = r_err;
  assign commit_count = r_commit_count;
  assign mis_pc       = r_mis.pc;
  assign mis_wdata    = r_mis.wdata;
  assign mis_waddr    = r_mis.waddr;

endmodule

// File: tb/tb_debug_trace_checker.sv
// Directed and randomized bench for debug_trace_checker against a queue-based
// model of the commit/golden comparison rules.
module tb_debug_trace_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dbg_pc = '0;
  logic [31:0] dbg_wdata = '0;
  logic [4:0]  dbg_waddr = '0;
  logic        dbg_wen = 1'b0;
  logic        g_valid = 1'b0;
  logic [31:0] g_pc = '0;
  logic [31:0] g_wdata = '0;
  logic [4:0]  g_waddr = '0;
  logic        g_last = 1'b0;
  logic        golden_ready;
  logic [1:0]  status;
  logic [1:0]  err_code;
  logic [31:0] commit_count;
  logic [31:0] mis_pc;
  logic [31:0] mis_wdata;
  logic [4:0]  mis_waddr;

  debug_trace_checker #(
    .DEPTH     (8),
    .FILTER_R0 (1'b1)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io_debug_pc    (dbg_pc),
    .io_debug_wdata (dbg_wdata),
    .io_debug_waddr (dbg_waddr),
    .io_debug_wen   (dbg_wen),
    .golden_valid   (g_valid),
    .golden_ready   (golden_ready),
    .golden_pc      (g_pc),
    .golden_wdata   (g_wdata),
    .golden_waddr   (g_waddr),
    .golden_last    (g_last),
    .status         (status),
    .err_code       (err_code),
    .commit_count   (commit_count),
    .mis_pc         (mis_pc),
    .mis_wdata      (mis_wdata),
    .mis_waddr      (mis_waddr)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: status 0 run / 1 pass / 2 fail; err 0 none / 1 mismatch / 2 overflow.
  logic [1:0]  m_status;
  logic [1:0]  m_err;
  logic [31:0] m_count;
  logic [68:0] m_mis;
  logic [68:0] m_q[$];

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return (m_status == 2'd0) && (m_q.size() != 0);
  endfunction

  task automatic model_reset();
    m_status = 2'd0;
    m_err    = 2'd0;
    m_count  = '0;
    m_mis    = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit          cmp;
    bit          enq;
    logic [68:0] obs;
    logic [68:0] gold;
    logic [68:0] head;
    cmp  = g_valid && m_ready();
    enq  = dbg_wen && (m_status == 2'd0) && (dbg_waddr != 5'd0);
    obs  = {dbg_pc, dbg_waddr, dbg_wdata};
    gold = {g_pc, g_waddr, g_wdata};
    if (m_status != 2'd0) return;
    if (cmp && (m_q[0] != gold)) begin
      m_status = 2'd2;
      m_err    = 2'd1;
      m_mis    = m_q[0];
    end else if (enq && (m_q.size() == 8) && !cmp) begin
      m_status = 2'd2;
      m_err    = 2'd2;
      m_mis    = obs;
    end else begin
      if (cmp) begin
        head = m_q.pop_front();
        m_count++;
        if (g_last) m_status = 2'd1;
      end
      if (enq) m_q.push_back(obs);
    end
  endtask

  task automatic check_outputs();
    check("status", status, m_status);
    check("err_code", err_code, m_err);
    check("commit_count", commit_count, m_count);
    check("mis_pc", mis_pc, m_mis[68:37]);
    check("mis_waddr", mis_waddr, m_mis[36:32]);
    check("mis_wdata", mis_wdata, m_mis[31:0]);
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    check("golden_ready", golden_ready, m_ready());
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic set_commit(input bit en, input logic [31:0] pc, input logic [4:0] wa,
                            input logic [31:0] wd);
    dbg_wen = en; dbg_pc = pc; dbg_waddr = wa; dbg_wdata = wd;
  endtask

  task automatic set_gold(input bit v, input logic [31:0] pc, input logic [4:0] wa,
                          input logic [31:0] wd, input bit last);
    g_valid = v; g_pc = pc; g_waddr = wa; g_wdata = wd; g_last = last;
  endtask

  task automatic idle();
    set_commit(1'b0, '0, '0, '0);
    set_gold(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    #2;
    model_reset();
    check_outputs();
    check("reset_golden_ready", golden_ready, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic clean_run(input string tag);
    set_commit(1'b1, 32'hBFC00000, 5'd1, 32'h1); set_gold(1'b0, '0, '0, '0, 1'b0); tick();
    set_commit(1'b1, 32'hBFC00004, 5'd2, 32'h2); set_gold(1'b1, 32'hBFC00000, 5'd1, 32'h1, 1'b0); tick();
    set_commit(1'b1, 32'hBFC00008, 5'd3, 32'h3); set_gold(1'b1, 32'hBFC00004, 5'd2, 32'h2, 1'b0); tick();
    set_commit(1'b0, '0, '0, '0);               set_gold(1'b1, 32'hBFC00008, 5'd3, 32'h3, 1'b1); tick();
    check({tag, "_status"}, status, 2'd1);
    check({tag, "_count"}, commit_count, 32'd3);
    check({tag, "_err"}, err_code, 2'd0);
    // Commits after the pass are not errors and change nothing.
    set_commit(1'b1, 32'hBFC0000C, 5'd4, 32'h4); set_gold(1'b0, '0, '0, '0, 1'b0); tick();
    idle(); tick();
    check({tag, "_post_status"}, status, 2'd1);
    check({tag, "_post_count"}, commit_count, 32'd3);
  endtask

  initial begin
    logic [68:0] cq[$];
    logic [68:0] gq[$];
    logic [68:0] tmp;
    logic [4:0]  wa;
    int          n;
    int          ci;
    int          gi;
    int          bad;
    int          bit_ix;

    model_reset();
    #2;
    check_outputs();
    @(posedge clock);
    #1;
    do_reset();

    // Clean three-commit run.
    clean_run("clean");

    // Data mismatch on the second commit.
    do_reset();
    set_commit(1'b1, 32'hBFC00000, 5'd1, 32'h1); tick();
    set_commit(1'b1, 32'hBFC00004, 5'd2, 32'h5); set_gold(1'b1, 32'hBFC00000, 5'd1, 32'h1, 1'b0); tick();
    set_commit(1'b1, 32'hBFC00008, 5'd3, 32'h3); set_gold(1'b1, 32'hBFC00004, 5'd2, 32'h2, 1'b0); tick();
    check("mm_status", status, 2'd2);
    check("mm_err", err_code, 2'd1);
    check("mm_pc", mis_pc, 32'hBFC00004);
    check("mm_wdata", mis_wdata, 32'h5);
    check("mm_count", commit_count, 32'd1);
    set_commit(1'b1, 32'hBFC0000C, 5'd4, 32'h4); set_gold(1'b1, 32'hBFC00008, 5'd3, 32'h3, 1'b1); tick();
    idle(); tick();
    check("mm_frozen_count", commit_count, 32'd1);
    check("mm_frozen_pc", mis_pc, 32'hBFC00004);

    // Commits to r0 are filtered and never compared.
    do_reset();
    set_commit(1'b1, 32'h00000100, 5'd1, 32'hA); tick();
    set_commit(1'b1, 32'h00000104, 5'd0, 32'hB); set_gold(1'b1, 32'h00000100, 5'd1, 32'hA, 1'b0); tick();
    set_commit(1'b1, 32'h00000108, 5'd2, 32'hC); set_gold(1'b0, '0, '0, '0, 1'b0); tick();
    set_commit(1'b0, '0, '0, '0);               set_gold(1'b1, 32'h00000108, 5'd2, 32'hC, 1'b1); tick();
    idle(); tick();
    check("r0_status", status, 2'd1);
    check("r0_count", commit_count, 32'd2);

    // Nine commits with no golden consumption overflow the eight-entry FIFO.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_commit(1'b1, 32'h80000000 + 32'(4 * i), 5'(i + 1), 32'(i)); tick();
    end
    idle(); tick();
    check("ovf_status", status, 2'd2);
    check("ovf_err", err_code, 2'd2);
    check("ovf_pc", mis_pc, 32'h80000020);

    // Fill to full, then push and pop together for 20 cycles.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_commit(1'b1, 32'h1000 + 32'(4 * i), 5'((i % 31) + 1), ~32'(i)); tick();
    end
    for (int k = 0; k < 20; k++) begin
      set_commit(1'b1, 32'h1000 + 32'(4 * (k + 8)), 5'(((k + 8) % 31) + 1), ~32'(k + 8));
      set_gold(1'b1, 32'h1000 + 32'(4 * k), 5'((k % 31) + 1), ~32'(k), 1'b0);
      tick();
    end
    idle(); tick();
    check("full_count", commit_count, 32'd20);
    check("full_status", status, 2'd0);
    check("full_err", err_code, 2'd0);

    // Reset with five entries queued, then a fresh clean run.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_commit(1'b1, 32'h2000 + 32'(4 * i), 5'(i + 1), 32'(i)); tick();
    end
    idle();
    do_reset();
    clean_run("after_reset");

    // Randomized traces, every other one with a single corrupted golden bit.
    for (int r = 0; r < 12; r++) begin
      do_reset();
      cq.delete();
      gq.delete();
      n = $urandom_range(6, 24);
      for (int i = 0; i < n; i++) begin
        wa = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        tmp = {32'($urandom), wa, 32'($urandom)};
        cq.push_back(tmp);
        if (wa != 5'd0) gq.push_back(tmp);
      end
      if ((r % 2) == 1 && gq.size() > 0) begin
        bad    = $urandom_range(0, gq.size() - 1);
        bit_ix = $urandom_range(0, 68);
        tmp    = gq[bad];
        tmp[bit_ix] = ~tmp[bit_ix];
        gq[bad] = tmp;
      end
      ci = 0;
      gi = 0;
      for (int c = 0; c < 120 && m_status == 2'd0; c++) begin
        if (ci < cq.size() && $urandom_range(0, 1) == 1) begin
          {dbg_pc, dbg_waddr, dbg_wdata} = cq[ci];
          dbg_wen = 1'b1;
          ci++;
        end else begin
          dbg_wen = 1'b0;
        end
        if (gi < gq.size() && $urandom_range(0, 2) != 0) begin
          {g_pc, g_waddr, g_wdata} = gq[gi];
          g_valid = 1'b1;
          g_last  = (gi == gq.size() - 1);
          if (m_ready()) gi++;
        end else begin
          g_valid = 1'b0;
          g_last  = 1'b0;
        end
        tick();
      end
      idle(); tick(); tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
